// File: rtl/jpeg_byte_unstuffer_pkg.sv
// Shared constants and state encoding for the JPEG entropy-stream front end.
package jpeg_pkg;

    // Byte values with special meaning inside entropy-coded data
    localparam logic [7:0] JPEG_FF    = 8'hFF;
    localparam logic [7:0] JPEG_STUFF = 8'h00;

    // Marker codes of interest to downstream consumers
    localparam logic [7:0] M_SOI  = 8'hD8;
    localparam logic [7:0] M_EOI  = 8'hD9;
    localparam logic [7:0] M_RST0 = 8'hD0;

    // Unstuffer FSM: NORM passes bytes, FF_SEEN holds a pending 0xFF
    typedef enum logic {
        NORM,
        FF_SEEN
    } state_t;

endpackage

// File: rtl/jpeg_byte_unstuffer.sv
// Removes 0xFF/0x00 stuffing and 0xFF fill bytes from a JPEG scan stream,
// reports markers on an acknowledged side channel, and counts stuffing bytes.
module jpeg_byte_unstuffer
    import jpeg_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [7:0]       OUT_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             MARKER_VALID,
    output logic [7:0]       MARKER_CODE,
    input  logic             MARKER_ACK,
    output logic [CNT_W-1:0] STUFF_CNT
);

    state_t           state_q, state_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             marker_valid_q, marker_valid_d;
    logic [7:0]       marker_code_q, marker_code_d;
    logic [CNT_W-1:0] stuff_cnt_q, stuff_cnt_d;
    logic             in_ready;
    logic             accept;

    // Input is taken only when the output slot is free or draining and no
    // marker is outstanding; this keeps data bytes ahead of any marker.
    always_comb begin
        in_ready = !RST && (!out_valid_q || OUT_READY) && !marker_valid_q;
        accept   = IN_VALID && in_ready;
    end

    // Next-state and next-output decode for the unstuffing FSM
    always_comb begin
        state_d        = state_q;
        out_data_d     = out_data_q;
        out_valid_d    = out_valid_q && !OUT_READY;
        marker_valid_d = marker_valid_q && !MARKER_ACK;
        marker_code_d  = marker_code_q;
        stuff_cnt_d    = stuff_cnt_q;

        if (accept) begin
            unique case (state_q)
                NORM: begin
                    if (IN_DATA == JPEG_FF) begin
                        state_d = FF_SEEN;
                    end else begin
                        out_data_d  = IN_DATA;
                        out_valid_d = 1'b1;
                    end
                end
                FF_SEEN: begin
                    if (IN_DATA == JPEG_STUFF) begin
                        out_data_d  = JPEG_FF;
                        out_valid_d = 1'b1;
                        state_d     = NORM;
                        if (stuff_cnt_q != '1) begin
                            stuff_cnt_d = stuff_cnt_q + 1'b1;
                        end
                    end else if (IN_DATA == JPEG_FF) begin
                        // Fill byte: keep waiting for the byte after the run
                        state_d = FF_SEEN;
                    end else begin
                        marker_valid_d = 1'b1;
                        marker_code_d  = IN_DATA;
                        state_d        = NORM;
                    end
                end
                default: state_d = NORM;
            endcase
        end
    end

    // State, output register, marker channel and counter storage
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q        <= NORM;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            marker_valid_q <= 1'b0;
            marker_code_q  <= '0;
            stuff_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            marker_valid_q <= marker_valid_d;
            marker_code_q  <= marker_code_d;
            stuff_cnt_q    <= stuff_cnt_d;
        end
    end

    assign IN_READY     = in_ready;
    assign OUT_DATA     = out_data_q;
    assign OUT_VALID    = out_valid_q;
    assign MARKER_VALID = marker_valid_q;
    assign MARKER_CODE  = marker_code_q;
    assign STUFF_CNT    = stuff_cnt_q;

endmodule

// File: tb/tb_jpeg_byte_unstuffer.sv
// Bench for jpeg_byte_unstuffer: table of bytes with expected outputs,
// expected bytes/markers queued at accept and checked as the DUT emits them.
module tb_jpeg_byte_unstuffer;
    import jpeg_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        marker_valid;
    logic [7:0]  marker_code;
    logic        marker_ack = 1'b0;
    logic [15:0] stuff_cnt;

    logic        sat_in_ready;
    logic [7:0]  sat_out_data;
    logic        sat_out_valid;
    logic        sat_marker_valid;
    logic [7:0]  sat_marker_code;
    logic [1:0]  sat_stuff_cnt;

    always #5 clk = ~clk;

    jpeg_byte_unstuffer #(.CNT_W(16)) u_dut (
        .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_VALID(in_valid),
        .IN_READY(in_ready), .OUT_DATA(out_data), .OUT_VALID(out_valid),
        .OUT_READY(out_ready), .MARKER_VALID(marker_valid),
        .MARKER_CODE(marker_code), .MARKER_ACK(marker_ack), .STUFF_CNT(stuff_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation
    jpeg_byte_unstuffer #(.CNT_W(2)) u_sat (
        .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_VALID(in_valid),
        .IN_READY(sat_in_ready), .OUT_DATA(sat_out_data), .OUT_VALID(sat_out_valid),
        .OUT_READY(out_ready), .MARKER_VALID(sat_marker_valid),
        .MARKER_CODE(sat_marker_code), .MARKER_ACK(marker_ack), .STUFF_CNT(sat_stuff_cnt)
    );

    typedef struct {
        int         grp;
        logic [7:0] data;
        bit         eo;   // expect a data byte from this input
        logic [7:0] ob;   // expected data byte
        bit         em;   // expect a marker with code == data
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    logic [7:0] mark_q[$];
    int         total = 0;
    int         bad = 0;
    int         rdy_mode = 0;   // 0 high, 1 toggle, 2 low
    int         ack_delay = 0;
    bit         ack_idle = 1'b0;
    bit         lat_pend = 1'b0;
    vec_t       lat_vec;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void add(input int g, input logic [7:0] d, input bit eo,
                                input logic [7:0] ob, input bit em);
        vec_t v;
        v.grp = g; v.data = d; v.eo = eo; v.ob = ob; v.em = em;
        vecs.push_back(v);
    endfunction

    // Drive one byte (called at posedge+1), wait bounded for accept
    task automatic send_byte(input vec_t v);
        int n;
        in_data  = v.data;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 32'(v.data), 32'hFFFF_FFFF);
                in_valid = 1'b0;
                return;
            end
        end
        if (v.eo) exp_q.push_back(v.ob);
        if (v.em) mark_q.push_back(v.data);
        @(posedge clk);
        #1;
        lat_vec  = v;
        lat_pend = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic run_group(input int g);
        @(posedge clk);
        #1;
        foreach (vecs[i]) if (vecs[i].grp == g) send_byte(vecs[i]);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || mark_q.size() != 0 || lat_pend) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 32'(exp_q.size() + mark_q.size()), 0);
    endtask

    // OUT_READY pattern generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard and marker acknowledger, sampled on falling edge
    initial begin
        bit         prev_stall = 1'b0;
        logic [7:0] prev_data = '0;
        bit         prev_mv = 1'b0;
        logic [7:0] prev_code = '0;
        int         hi = 0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                prev_mv = 1'b0;
                hi = 0;
                marker_ack = 1'b0;
                lat_pend = 1'b0;
            end else begin
                if (marker_valid || out_valid)
                    chk("no_overlap", {31'b0, marker_valid & out_valid}, 0);
                if (lat_pend) begin
                    lat_pend = 1'b0;
                    if (lat_vec.eo) begin
                        chk("latency_valid", {31'b0, out_valid}, 1);
                        chk("latency_data", {24'b0, out_data}, {24'b0, lat_vec.ob});
                    end
                    if (lat_vec.em) begin
                        chk("marker_latency", {31'b0, marker_valid}, 1);
                        chk("marker_code_now", {24'b0, marker_code}, {24'b0, lat_vec.data});
                    end
                end
                if (prev_stall) begin
                    chk("stall_valid", {31'b0, out_valid}, 1);
                    chk("stall_data", {24'b0, out_data}, {24'b0, prev_data});
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", {24'b0, out_data}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_byte", {24'b0, out_data}, {24'b0, e});
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;

                if (marker_valid) begin
                    chk("stall_on_marker", {31'b0, in_ready}, 0);
                    if (!prev_mv) begin
                        if (mark_q.size() == 0) begin
                            chk("unexpected_marker", {24'b0, marker_code}, 32'hFFFF_FFFF);
                        end else begin
                            e = mark_q.pop_front();
                            chk("marker_code", {24'b0, marker_code}, {24'b0, e});
                        end
                    end else begin
                        chk("marker_hold_code", {24'b0, marker_code}, {24'b0, prev_code});
                    end
                    hi++;
                    marker_ack = (hi == ack_delay + 1);
                end else begin
                    if (prev_mv) chk("marker_hold_cycles", hi, ack_delay + 1);
                    hi = 0;
                    marker_ack = ack_idle;
                end
                prev_mv   = marker_valid;
                prev_code = marker_code;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // grp 1: basic stuffing
        add(1, 8'h12, 1, 8'h12, 0); add(1, 8'h34, 1, 8'h34, 0);
        add(1, 8'hFF, 0, 8'h00, 0); add(1, 8'h00, 1, 8'hFF, 0);
        add(1, 8'h56, 1, 8'h56, 0);
        // grp 2: fill bytes then marker, delayed ACK
        add(2, 8'hAB, 1, 8'hAB, 0); add(2, 8'hFF, 0, 8'h00, 0);
        add(2, 8'hFF, 0, 8'h00, 0); add(2, 8'hFF, 0, 8'h00, 0);
        add(2, 8'hD3, 0, 8'h00, 1); add(2, 8'hCD, 1, 8'hCD, 0);
        // grp 3: 01..0A under back-pressure
        for (int unsigned i = 1; i <= 10; i++) add(3, 8'(i), 1, 8'(i), 0);
        // grp 4: dangling FF before reset; grp 5: after reset
        add(4, 8'hFF, 0, 8'h00, 0);
        add(5, 8'h00, 1, 8'h00, 0); add(5, 8'h11, 1, 8'h11, 0);
        // grp 6: five stuffed pairs
        for (int unsigned i = 0; i < 5; i++) begin
            add(6, 8'hFF, 0, 8'h00, 0); add(6, 8'h00, 1, 8'hFF, 0);
        end

        // Reset values
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 0);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_out_data", {24'b0, out_data}, 0);
        chk("rst_marker_valid", {31'b0, marker_valid}, 0);
        chk("rst_marker_code", {24'b0, marker_code}, 0);
        chk("rst_stuff_cnt", {16'b0, stuff_cnt}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        ack_idle = 1'b1;   // stray ACKs with no marker must be ignored
        run_group(1);
        drain();
        ack_idle = 1'b0;
        chk("stuff_after_g1", {16'b0, stuff_cnt}, 1);

        ack_delay = 5;
        run_group(2);
        drain();
        ack_delay = 0;
        chk("stuff_after_g2", {16'b0, stuff_cnt}, 1);

        rdy_mode = 1;
        run_group(3);
        rdy_mode = 0;
        drain();

        // Pending FF discarded by an asynchronous reset mid-cycle
        run_group(4);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_in_ready", {31'b0, in_ready}, 0);
        chk("arst_out_valid", {31'b0, out_valid}, 0);
        chk("arst_out_data", {24'b0, out_data}, 0);
        chk("arst_marker_valid", {31'b0, marker_valid}, 0);
        chk("arst_stuff_cnt", {16'b0, stuff_cnt}, 0);
        chk("arst_sat_outputs", {sat_in_ready, sat_out_valid, sat_marker_valid,
                                 sat_stuff_cnt, sat_out_data, sat_marker_code}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        mark_q.delete();
        run_group(5);
        drain();
        chk("stuff_after_reset", {16'b0, stuff_cnt}, 0);

        run_group(6);
        drain();
        chk("stuff_five", {16'b0, stuff_cnt}, 5);
        chk("stuff_saturated", {30'b0, sat_stuff_cnt}, 3);

        // Marker behind a stalled data byte
        begin
            vec_t v;
            rdy_mode = 2;
            @(posedge clk);
            #1;
            v.grp = 7; v.data = 8'h77; v.eo = 1; v.ob = 8'h77; v.em = 0;
            send_byte(v);
            fork
                begin
                    vec_t a;
                    vec_t b;
                    a.grp = 7; a.data = JPEG_FF; a.eo = 0; a.ob = 8'h00; a.em = 0;
                    b.grp = 7; b.data = M_EOI;   b.eo = 0; b.ob = 8'h00; b.em = 1;
                    send_byte(a);
                    send_byte(b);
                end
                begin
                    repeat (4) @(posedge clk);
                    chk("held_byte_pending", {31'b0, out_valid}, 1);
                    rdy_mode = 0;
                end
            join
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jpeg_byte_unstuffer.md
Name: jpeg_byte_unstuffer

Overview:
- Entropy-stream front end of the JPEG decoder. Sits directly upstream of the Huffman/bit-extraction stage and feeds it clean scan bytes.
- Removes the 0x00 stuffing byte that follows every 0xFF in entropy-coded data and drops 0xFF fill bytes.
- Detects markers (0xFF followed by a non-zero, non-0xFF byte) and reports them on a separate, acknowledged channel.
- Also keeps a saturating count of removed stuffing bytes for debug.

Parameters:
- CNT_W, 16: width of the stuffing-byte counter.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- IN_DATA  input  8  compressed byte from the bitstream fetch.
- IN_VALID  input  1  IN_DATA valid.
- IN_READY  output  1  block accepts IN_DATA this cycle.
- OUT_DATA  output  8  unstuffed scan byte to the Huffman stage.
- OUT_VALID  output  1  OUT_DATA valid.
- OUT_READY  input  1  downstream accepts OUT_DATA.
- MARKER_VALID  output  1  marker detected; held until acknowledged.
- MARKER_CODE  output  8  second byte of the marker (e.g. 0xD0–0xD7 RSTn, 0xD9 EOI).
- MARKER_ACK  input  1  marker consumer acknowledges.
- STUFF_CNT  output  CNT_W  number of 0x00 stuffing bytes removed, saturating.

Behaviour:
- Reset (async, RST=1):
  - OUT_VALID=0, OUT_DATA=0x00.
  - MARKER_VALID=0, MARKER_CODE=0x00.
  - STUFF_CNT=0.
  - State=NORM.
  - IN_READY is low while RST is high.
  - Reset mid-stream discards any pending 0xFF and any unacknowledged marker.
- Accept condition: accept = IN_VALID && IN_READY.
  - IN_READY = !RST && (!OUT_VALID || OUT_READY) && !MARKER_VALID.
- Output register:
  - Single-entry. Data latency is 1 cycle from accept to OUT_VALID.
  - OUT_DATA is stable while OUT_VALID && !OUT_READY.
  - OUT_VALID clears on an OUT_READY handshake unless a new byte is loaded in the same cycle.
  - With OUT_READY held high, throughput is 1 byte/cycle.
- State NORM, on accept of byte b:
  - b != 0xFF: load OUT_DATA=b, OUT_VALID=1; stay in NORM.
  - b == 0xFF: no output; go to FF_SEEN.
- State FF_SEEN, on accept of byte b:
  - b == 0x00: load OUT_DATA=0xFF, OUT_VALID=1; STUFF_CNT+=1, saturating at all-ones; go to NORM.
  - b == 0xFF: fill byte, dropped; no output; stay in FF_SEEN.
  - Otherwise: MARKER_VALID=1 and MARKER_CODE=b on the next edge; no data output; go to NORM.
- State with no accept: unchanged.
- Marker channel:
  - MARKER_VALID and MARKER_CODE hold until a cycle with MARKER_ACK=1; MARKER_VALID then clears on that edge.
  - MARKER_ACK while MARKER_VALID=0 is ignored.
  - Input is stalled while MARKER_VALID=1. The first post-marker byte can be accepted the cycle after the ACK cycle.
- Ordering:
  - Because accept requires the output register to be empty or draining, every data byte preceding a marker has left the block before MARKER_VALID rises.
  - MARKER_VALID and OUT_VALID are never both 1.
- Simultaneous events:
  - OUT_READY handshake and new accept in the same cycle: the new byte replaces the old one and OUT_VALID stays 1.
  - MARKER_ACK and IN_VALID in the same cycle: the input is not accepted that cycle.
- Boundary cases:
  - IN_VALID may drop while in FF_SEEN; the pending 0xFF is retained indefinitely.
  - STUFF_CNT does not wrap.

Decomposition:
- Shared package jpeg_pkg, holding:
  - constants JPEG_FF=8'hFF, JPEG_STUFF=8'h00;
  - marker codes M_SOI=8'hD8, M_EOI=8'hD9, M_RST0=8'hD0;
  - the state enum {NORM, FF_SEEN}.
- No sub-module. Single FSM plus output register plus counter.

Test Plan:
- Stream 12 34 FF 00 56, OUT_READY=1 → OUT: 12 34 FF 56, one cycle after each accept (FF appears one cycle after the 00 is accepted); STUFF_CNT=1; no marker.
- Stream AB FF FF FF D3 CD, no ACK for 5 cycles then ACK → OUT: AB; MARKER_VALID=1, CODE=D3 held 5 cycles; IN_READY=0 throughout; CD output after ACK.
- Stream 01..0A, OUT_READY toggling 1/0 → every byte delivered exactly once, in order; OUT_DATA stable during stalls; no byte loss or duplication.
- Send FF, then RST pulse, then 00 11 → OUT: 00 11 (the 00 is plain data, not stuffing); STUFF_CNT=0; all outputs zero during reset.
- CNT_W=2, stream (FF 00)×5 → STUFF_CNT saturates at 3; five FF bytes output.
- Stream FF D9 with OUT_VALID stalled on a previous byte 77 → marker not raised until 77 is taken; then MARKER_VALID=1, CODE=D9, never overlapping OUT_VALID.
